pipe_result_writer: RTL and testbench

PIPE_RESULT_WRITER -- requirements
Module: pipe_result_writer

---
 rtl/pipe_result_writer.sv | 172 +++++++++++++++++
 tb/tb_pipe_result_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_writer.sv
// Buffers pipe-stage results in a small FIFO and streams them to banked SRAM,
// assigning per-stage sequential word addresses and tracking finish/drain.
module pipe_result_writer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  valid_i,
    input  logic [2:0]            stage_i,
    input  logic                  finished_i,
    input  logic [WIDTH-1:0]      operand1_i,
    input  logic [WIDTH-1:0]      operand2_i,
    output logic                  stall_o,
    output logic                  wr_en_o,
    input  logic                  wr_ready_i,
    output logic [2:0]            wr_bank_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [2*WIDTH-1:0]    wr_data_o,
    output logic                  done_o,
    output logic                  wrap_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DATA_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [2:0]          last_stage_q, last_stage_d;
    logic                wrap_q, wrap_d;
    logic                stall_q, stall_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;

    logic                accepting_c;
    logic                push_c;
    logic                pop_c;
    logic                same_stage_c;
    logic [ADDR_W-1:0]   push_addr_c;
    logic [DATA_W-1:0]   push_data_c;

    logic [2:0]          bank_mem [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    // Next-state, FIFO control and address generation
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        addr_cnt_d   = addr_cnt_q;
        last_stage_d = last_stage_q;
        wrap_d       = wrap_q;
        stall_d      = 1'b0;
        wr_en_d      = 1'b0;
        done_d       = 1'b0;

        accepting_c  = (state_q == S_IDLE) || (state_q == S_RUN);
        push_c       = valid_i && !stall_q && (stage_i != 3'd7) && accepting_c;
        pop_c        = wr_en_q && wr_ready_i;
        same_stage_c = (stage_i == last_stage_q);
        push_addr_c  = same_stage_c ? addr_cnt_q + ADDR_W'(1) : '0;
        push_data_c  = {(stage_i == 3'd6) ? operand2_i : WIDTH'(0), operand1_i};

        if (push_c) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            addr_cnt_d   = push_addr_c;
            last_stage_d = stage_i;
            if (same_stage_c && (addr_cnt_q == {ADDR_W{1'b1}})) begin
                wrap_d = 1'b1;
            end
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (finished_i) begin
                    state_d = S_DRAIN;
                end else if (push_c) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (finished_i) begin
                    state_d = S_DRAIN;
                end
            end
            // Leave only once an empty FIFO has been observed for a full cycle
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall_d = (count_d == CNT_W'(DEPTH)) &&
                  ((state_d == S_IDLE) || (state_d == S_RUN));
        wr_en_d = (count_d != '0);
        done_d  = (state_d == S_DONE);
    end

    // Control state register
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            addr_cnt_q   <= '0;
            last_stage_q <= 3'd7;
            wrap_q       <= 1'b0;
            stall_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            addr_cnt_q   <= addr_cnt_d;
            last_stage_q <= last_stage_d;
            wrap_q       <= wrap_d;
            stall_q      <= stall_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
        end
    end

    // FIFO payload storage; contents are qualified by count, so no reset
    always_ff @(posedge CLK_i) begin
        if (push_c) begin
            bank_mem[wr_ptr_q] <= stage_i;
            addr_mem[wr_ptr_q] <= push_addr_c;
            data_mem[wr_ptr_q] <= push_data_c;
        end
    end

    assign stall_o   = stall_q;
    assign wr_en_o   = wr_en_q;
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;
    assign wr_bank_o = bank_mem[rd_ptr_q];
    assign wr_addr_o = addr_mem[rd_ptr_q];
    assign wr_data_o = data_mem[rd_ptr_q];

endmodule

// File: tb/tb_pipe_result_writer.sv
// Directed self-checking bench for pipe_result_writer (ADDR_W=2 so the
// address wrap is reachable in a handful of pushes).
module tb_pipe_result_writer;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    logic                clk;
    logic                rst;
    logic                valid;
    logic [2:0]          stage;
    logic                finished;
    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2;
    logic                stall;
    logic                wr_en;
    logic                wr_ready;
    logic [2:0]          wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [2*WIDTH-1:0]  wr_data;
    logic                done;
    logic                wrap;

    int n_cmp = 0;
    int n_err = 0;

    pipe_result_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK_i      (clk),
        .RST_i      (rst),
        .valid_i    (valid),
        .stage_i    (stage),
        .finished_i (finished),
        .operand1_i (op1),
        .operand2_i (op2),
        .stall_o    (stall),
        .wr_en_o    (wr_en),
        .wr_ready_i (wr_ready),
        .wr_bank_o  (wr_bank),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .done_o     (done),
        .wrap_o     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [2:0] bank,
                            input logic [1:0] addr, input logic [31:0] data);
        chk({tag, ".en"},   32'(wr_en),   32'd1);
        chk({tag, ".bank"}, 32'(wr_bank), 32'(bank));
        chk({tag, ".addr"}, 32'(wr_addr), 32'(addr));
        chk({tag, ".data"}, wr_data,      data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        finished = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] wrap_addr [5];
    logic       wrap_flag [5];

    initial begin
        rst = 1'b1; valid = 1'b0; stage = 3'd0; finished = 1'b0;
        op1 = '0; op2 = '0; wr_ready = 1'b0;
        wrap_addr[0] = 2'd0; wrap_addr[1] = 2'd1; wrap_addr[2] = 2'd2;
        wrap_addr[3] = 2'd3; wrap_addr[4] = 2'd0;
        wrap_flag[0] = 1'b0; wrap_flag[1] = 1'b0; wrap_flag[2] = 1'b0;
        wrap_flag[3] = 1'b0; wrap_flag[4] = 1'b1;

        do_reset();
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.wrap",  32'(wrap),  32'd0);

        // Stage 1 stream with the SRAM always ready
        wr_ready = 1'b1; valid = 1'b1; stage = 3'd1;
        op1 = 16'h3C00; tick(); chk_head("s1.w0", 3'd1, 2'd0, 32'h0000_3C00);
        op1 = 16'h4000; tick(); chk_head("s1.w1", 3'd1, 2'd1, 32'h0000_4000);
        op1 = 16'h4200; tick(); chk_head("s1.w2", 3'd1, 2'd2, 32'h0000_4200);
        valid = 1'b0; tick();
        chk("s1.empty", 32'(wr_en), 32'd0);

        // Back-pressure: fill four, drop a fifth, then drain
        wr_ready = 1'b0; valid = 1'b1; stage = 3'd3;
        for (int i = 0; i < 4; i++) begin
            op1 = 16'(16'h0010 + i);
            tick();
        end
        chk("bp.stall_full", 32'(stall), 32'd1);
        op1 = 16'h0099; tick();
        valid = 1'b0;
        chk("bp.stall_hold", 32'(stall), 32'd1);
        chk_head("bp.w0", 3'd3, 2'd0, 32'h0000_0010);
        wr_ready = 1'b1; tick();
        chk("bp.stall_rel", 32'(stall), 32'd0);
        chk_head("bp.w1", 3'd3, 2'd1, 32'h0000_0011);
        tick(); chk_head("bp.w2", 3'd3, 2'd2, 32'h0000_0012);
        tick(); chk_head("bp.w3", 3'd3, 2'd3, 32'h0000_0013);
        tick(); chk("bp.fifth_dropped", 32'(wr_en), 32'd0);

        // Stage switch; operand2 only kept for stage 6
        valid = 1'b1; stage = 3'd5; op2 = 16'hAAAA;
        op1 = 16'h0001; tick(); chk_head("sw.b5a0", 3'd5, 2'd0, 32'h0000_0001);
        op1 = 16'h0002; tick(); chk_head("sw.b5a1", 3'd5, 2'd1, 32'h0000_0002);
        stage = 3'd6; op1 = 16'h0007; op2 = 16'h3BD7;
        tick(); chk_head("sw.b6a0", 3'd6, 2'd0, 32'h3BD7_0007);
        stage = 3'd7; op1 = 16'h0055; tick();
        chk("sw.stage7_dropped", 32'(wr_en), 32'd0);
        valid = 1'b0; op2 = '0;

        // Address wrap in stage 2
        valid = 1'b1; stage = 3'd2;
        for (int i = 0; i < 5; i++) begin
            op1 = 16'(16'h0100 + i);
            tick();
            chk_head($sformatf("wrap.w%0d", i), 3'd2, wrap_addr[i], 32'(16'h0100 + i));
            chk($sformatf("wrap.flag%0d", i), 32'(wrap), 32'(wrap_flag[i]));
        end
        valid = 1'b0; tick();
        chk("wrap.sticky", 32'(wrap), 32'd1);

        // Finish with entries pending, then drain
        do_reset();
        chk("fin.wrap_cleared", 32'(wrap), 32'd0);
        wr_ready = 1'b0; valid = 1'b1; stage = 3'd4;
        for (int i = 0; i < 3; i++) begin
            op1 = 16'(16'h0200 + i);
            tick();
        end
        valid = 1'b0; finished = 1'b1; tick();
        finished = 1'b0;
        valid = 1'b1; op1 = 16'h00EE; tick();
        valid = 1'b0;
        chk("fin.stall", 32'(stall), 32'd0);
        chk("fin.done_early", 32'(done), 32'd0);
        chk_head("fin.w0", 3'd4, 2'd0, 32'h0000_0200);
        wr_ready = 1'b1; tick();
        chk_head("fin.w1", 3'd4, 2'd1, 32'h0000_0201);
        tick(); chk_head("fin.w2", 3'd4, 2'd2, 32'h0000_0202);
        tick();
        chk("fin.empty", 32'(wr_en), 32'd0);
        chk("fin.done_not_yet", 32'(done), 32'd0);
        tick();
        chk("fin.done", 32'(done), 32'd1);
        valid = 1'b1; finished = 1'b1; stage = 3'd1; tick(); tick();
        valid = 1'b0; finished = 1'b0;
        chk("fin.done_sticky", 32'(done), 32'd1);
        chk("fin.done_no_write", 32'(wr_en), 32'd0);

        // Mid-run reset discards queued entries
        do_reset();
        chk("mrr.done_cleared", 32'(done), 32'd0);
        wr_ready = 1'b0; valid = 1'b1; stage = 3'd3;
        op1 = 16'h0301; tick();
        op1 = 16'h0302; tick();
        valid = 1'b0;
        chk("mrr.queued", 32'(wr_en), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("mrr.wr_en", 32'(wr_en), 32'd0);
        wr_ready = 1'b1; valid = 1'b1; stage = 3'd0; op1 = 16'h0055;
        tick();
        valid = 1'b0;
        chk_head("mrr.w0", 3'd0, 2'd0, 32'h0000_0055);
        tick();
        chk("mrr.count0", 32'(wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
